inst_rom_ctrl: RTL and testbench
================================

INST_ROM_CTRL -- requirements
Module: inst_rom_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 17, byte-address width of the external instruction memory.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: rom_ce_i  input  1  fetch request from CPU fetch stage; level, held while request outstanding.
REQ-005 Port: rom_addr_i  input  32 (`InstAddrBus)  fetch byte address; bits [1:0] ignored (word-aligned).
REQ-006 Port: flush_i  input  1  invalidate the last-word buffer.
REQ-007 Port: rom_data_o  output  32 (`InstBus)  fetched instruction word, little-endian.
REQ-008 Port: rom_ready_o  output  1  one-cycle pulse, rom_data_o valid for rom_addr_i.
REQ-009 Port: mem_a_o  output  ADDR_W  byte address to external memory.
REQ-010 Port: mem_rd_o  output  1  read strobe to external memory.
REQ-011 Port: mem_din_i  input  8  read data; valid exactly one cycle after the address/strobe cycle.

Function
REQ-012 FSM states: IDLE, FETCH, RESP; 2-bit byte counter cnt; latched word address base.
REQ-013 IDLE, rom_ce_i=1, buffer valid, buffer tag == rom_addr_i[ADDR_W-1:2], flush_i=0: hit, go RESP with buffer word.
REQ-014 IDLE, rom_ce_i=1, otherwise: miss, latch base, drive mem_a_o={base,2'b00}, mem_rd_o=1, cnt=0, go FETCH.
REQ-015 FETCH each cycle: capture mem_din_i into byte lane cnt; if cnt<3 drive mem_a_o={base,cnt+1}, mem_rd_o=1; cnt increments.
REQ-016 FETCH with cnt==3 after capture: write word+tag into buffer, set buffer valid, go RESP.
REQ-017 RESP: rom_ready_o=1 and rom_data_o=assembled word for exactly one cycle; next state IDLE.
REQ-018 Latency: miss -> rom_ready_o high 5 cycles after the cycle rom_ce_i is first sampled; hit -> 1 cycle after.
REQ-019 Byte order: byte at {base,00} -> rom_data_o[7:0], {base,11} -> rom_data_o[31:24].
REQ-020 FETCH and rom_ce_i=0: abort, go IDLE, no ready, buffer unchanged.
REQ-021 FETCH and rom_addr_i word differs from base: abort, latch new base, issue byte 0 of new address same cycle, cnt=0.
REQ-022 Address bits above ADDR_W+... i.e. rom_addr_i[31:ADDR_W] ignored (wrap-around in memory space).
REQ-023 flush_i=1: buffer valid cleared next edge; flush_i coincident with a would-be hit is a miss; flush_i during FETCH does not abort, and the completing fill sets valid.
REQ-024 rom_data_o holds last delivered word while rom_ready_o=0.
REQ-025 mem_rd_o=0 and mem_a_o=0 in IDLE (no issue) and RESP.
REQ-026 rom_ce_i held high on same address after a response: next response via hit path, i.e. ready every 2 cycles.

Reset
REQ-027 rst=1 at an edge: state IDLE, cnt=0, buffer valid=0, rom_data_o=`ZeroWord, rom_ready_o=0, mem_rd_o=0, mem_a_o=0.
REQ-028 Reset mid-FETCH discards the partial word; no ready pulse follows.

Structure
REQ-029 `ZeroWord, `InstBus, `InstAddrBus come from defs.v; state encodings are added to defs.v as `IRC_IDLE/`IRC_FETCH/`IRC_RESP.
REQ-030 Single module, no sub-module; it is the responder side of the CPU core rom_ce/rom_addr/rom_data port, with rom_ready_o added to that port.

Verification
REQ-031 Memory bytes 0x00..0x03 = 13,05,10,00; ce=1 addr=0x0 -> ready at cycle 5, rom_data_o=0x00100513; mem_a_o sequence 0,1,2,3.
REQ-032 Repeat addr=0x0 after REQ-031 -> ready 1 cycle after ce, mem_rd_o never asserted, data 0x00100513.
REQ-033 Fetch addr=0x4, switch addr to 0x8 in cycle 2 -> fetch restarts, mem_a_o=8,9,A,B, single ready with word at 0x8, none for 0x4.
REQ-034 Fill addr=0x0, pulse flush_i, request 0x0 again -> full 5-cycle miss observed.
REQ-035 Assert rst during cycle 3 of a miss -> all outputs zero next cycle, no ready; subsequent request to same addr is a miss.
REQ-036 addr=0x0002_0010 with ADDR_W=17 -> mem_a_o=0x00010..0x00013 (upper bits dropped); addr=0x13 -> treated as 0x10.

Source files
------------

// File: rtl/inst_rom_ctrl_pkg.sv
// Shared types and constants for the byte-serial instruction ROM controller.
package inst_rom_ctrl_pkg;

  localparam int INST_W      = 32;
  localparam int INST_ADDR_W = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    IRC_IDLE  = 2'd0,
    IRC_FETCH = 2'd1,
    IRC_RESP  = 2'd2
  } irc_state_e;

endpackage

// File: rtl/inst_rom_ctrl.sv
// Serves 32-bit instruction fetches from a byte-wide external memory (4 reads
// per word) with a one-word last-fetch buffer; hit 1 cycle, miss 5 cycles.
module inst_rom_ctrl
  import inst_rom_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [INST_ADDR_W-1:0] rom_addr_i,
  input  logic                   flush_i,
  output logic [INST_W-1:0]      rom_data_o,
  output logic                   rom_ready_o,
  output logic [ADDR_W-1:0]      mem_a_o,
  output logic                   mem_rd_o,
  input  logic [7:0]             mem_din_i
);

  localparam int TAG_W = ADDR_W - 2;

  irc_state_e        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [TAG_W-1:0]  base_q, base_d;
  logic [23:0]       asm_q, asm_d;
  logic [INST_W-1:0] buf_word_q, buf_word_d;
  logic [TAG_W-1:0]  buf_tag_q, buf_tag_d;
  logic              buf_vld_q, buf_vld_d;
  logic [INST_W-1:0] data_q, data_d;

  logic [TAG_W-1:0]  req_tag;
  logic [1:0]        cnt_inc;
  logic              hit;
  logic              unused_addr_bits;

  // Address bits above the memory space and the byte offset are don't-care.
  assign req_tag          = rom_addr_i[ADDR_W-1:2];
  assign unused_addr_bits = ^{rom_addr_i[INST_ADDR_W-1:ADDR_W], rom_addr_i[1:0]};
  assign cnt_inc          = cnt_q + 2'd1;
  assign hit              = buf_vld_q && (buf_tag_q == req_tag) && !flush_i;

  assign rom_data_o  = data_q;
  assign rom_ready_o = (state_q == IRC_RESP);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    asm_d      = asm_q;
    buf_word_d = buf_word_q;
    buf_tag_d  = buf_tag_q;
    buf_vld_d  = flush_i ? 1'b0 : buf_vld_q;
    data_d     = data_q;
    mem_a_o    = '0;
    mem_rd_o   = 1'b0;

    // Gated while reset is held so no stray strobe leaves during reset.
    if (!rst) begin
      case (state_q)
        IRC_IDLE: begin
          if (rom_ce_i) begin
            if (hit) begin
              data_d  = buf_word_q;
              state_d = IRC_RESP;
            end else begin
              base_d   = req_tag;
              mem_a_o  = {req_tag, 2'b00};
              mem_rd_o = 1'b1;
              cnt_d    = 2'd0;
              state_d  = IRC_FETCH;
            end
          end
        end

        IRC_FETCH: begin
          if (!rom_ce_i) begin
            cnt_d   = 2'd0;
            state_d = IRC_IDLE;
          end else if (req_tag != base_q) begin
            base_d   = req_tag;
            mem_a_o  = {req_tag, 2'b00};
            mem_rd_o = 1'b1;
            cnt_d    = 2'd0;
          end else begin
            case (cnt_q)
              2'd0:    asm_d[7:0]   = mem_din_i;
              2'd1:    asm_d[15:8]  = mem_din_i;
              2'd2:    asm_d[23:16] = mem_din_i;
              default: begin
                // Last byte arrives straight into the buffer; fill beats flush.
                buf_word_d = {mem_din_i, asm_q};
                buf_tag_d  = base_q;
                buf_vld_d  = 1'b1;
                data_d     = {mem_din_i, asm_q};
                state_d    = IRC_RESP;
              end
            endcase
            if (cnt_q != 2'd3) begin
              mem_a_o  = {base_q, cnt_inc};
              mem_rd_o = 1'b1;
            end
            cnt_d = cnt_inc;
          end
        end

        IRC_RESP: state_d = IRC_IDLE;

        default: state_d = IRC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IRC_IDLE;
      cnt_q      <= 2'd0;
      base_q     <= '0;
      asm_q      <= '0;
      buf_word_q <= ZERO_WORD;
      buf_tag_q  <= '0;
      buf_vld_q  <= 1'b0;
      data_q     <= ZERO_WORD;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      asm_q      <= asm_d;
      buf_word_q <= buf_word_d;
      buf_tag_q  <= buf_tag_d;
      buf_vld_q  <= buf_vld_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Scoreboard bench for inst_rom_ctrl against a byte-wide memory model.
module tb_inst_rom_ctrl;
  import inst_rom_ctrl_pkg::*;

  localparam int ADDR_W = 17;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic              flush;
  logic [31:0]       addr;
  logic [31:0]       data;
  logic              ready;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_rd;
  logic [7:0]        mem_din;

  always #5 clk = ~clk;

  inst_rom_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_ce_i    (ce),
    .rom_addr_i  (addr),
    .flush_i     (flush),
    .rom_data_o  (data),
    .rom_ready_o (ready),
    .mem_a_o     (mem_a),
    .mem_rd_o    (mem_rd),
    .mem_din_i   (mem_din)
  );

  logic [7:0] mem [0:255];

  // Read data returns one cycle after the strobe; garbage otherwise.
  always @(posedge clk) mem_din <= mem_rd ? mem[mem_a[7:0]] : 8'hEE;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0;
  logic [31:0]       exp_q[$];
  int                ready_cyc[$];
  logic [ADDR_W-1:0] alog[$];

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0] & 8'hFC;
    return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
  endfunction

  // Monitor: samples mid-low-phase, after inputs changed at negedge settle.
  always begin
    @(negedge clk);
    #2;
    if (mem_rd === 1'b1) begin
      alog.push_back(mem_a);
      rd_cnt++;
    end else if (!rst) begin
      n_vec++;
      if (mem_a !== '0) begin
        n_err++;
        $display("FAIL idle_addr: mem_a_o=%h with no strobe, required 0", mem_a);
      end
    end
    if (ready === 1'b1) begin
      ready_cyc.push_back(cyc);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_ready: ready with data %h at cycle %0d, required no ready", data, cyc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          n_err++;
          $display("FAIL ready_data: got %h, required %h", data, e);
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] a, input bit fl, input int exp_lat,
                          input int exp_rd, input string name);
    int  start;
    int  lat;
    bit  seen;
    logic [31:0] e;
    e = exp_word(a);
    lat = 0;
    seen = 0;
    @(negedge clk);
    alog.delete();
    rd_cnt = 0;
    exp_q.push_back(e);
    ce = 1'b1;
    addr = a;
    flush = fl;
    start = cyc;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      flush = 1'b0;
      if (ready === 1'b1) begin
        seen = 1;
        lat = cyc - start;
      end
    end
    ce = 1'b0;
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s_timeout: no ready within 20 cycles, required latency %0d", name, exp_lat);
    end else if (lat != exp_lat) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, exp_lat);
    end
    @(negedge clk);
    #3;
    n_vec++;
    if (ready !== 1'b0 || data !== e) begin
      n_err++;
      $display("FAIL %s_hold: ready=%b data=%h, required ready=0 data=%h", name, ready, data, e);
    end
    n_vec++;
    if (rd_cnt != exp_rd) begin
      n_err++;
      $display("FAIL %s_reads: got %0d strobes, required %0d", name, rd_cnt, exp_rd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (ready !== 1'b0 || data !== 32'h0 || mem_rd !== 1'b0 || mem_a !== '0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b data=%h rd=%b a=%h, required all zero", ready, data, mem_rd, mem_a);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_miss();
    logic [ADDR_W-1:0] ea [4];
    ea = '{17'h0, 17'h1, 17'h2, 17'h3};
    do_fetch(32'h0, 1'b0, 5, 4, "miss");
    n_vec++;
    if (data !== 32'h0010_0513) begin
      n_err++;
      $display("FAIL miss_word: got %h, required 00100513", data);
    end
    n_vec++;
    if (alog.size() != 4) begin
      n_err++;
      $display("FAIL miss_addr_count: got %0d, required 4", alog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (alog[i] !== ea[i]) begin
          n_err++;
          $display("FAIL miss_addr[%0d]: got %h, required %h", i, alog[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_hit();
    do_fetch(32'h0, 1'b0, 1, 0, "hit");
  endtask

  task automatic test_restart();
    int start;
    int lat;
    bit seen;
    logic [ADDR_W-1:0] ea [6];
    ea = '{17'h4, 17'h5, 17'h8, 17'h9, 17'hA, 17'hB};
    seen = 0;
    lat = 0;
    @(negedge clk);
    alog.delete();
    exp_q.push_back(exp_word(32'h8));
    ce = 1'b1;
    addr = 32'h4;
    start = cyc;
    repeat (2) @(negedge clk);
    addr = 32'h8;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = 1;
        lat = cyc - start;
      end
    end
    ce = 1'b0;
    @(negedge clk);
    n_vec++;
    if (!seen || lat != 7) begin
      n_err++;
      $display("FAIL restart_latency: seen=%0d latency %0d, required 7", seen, lat);
    end
    n_vec++;
    if (alog.size() != 6) begin
      n_err++;
      $display("FAIL restart_addr_count: got %0d, required 6", alog.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++;
        if (alog[i] !== ea[i]) begin
          n_err++;
          $display("FAIL restart_addr[%0d]: got %h, required %h", i, alog[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    do_fetch(32'h0, 1'b0, 5, 4, "refill");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    do_fetch(32'h0, 1'b0, 5, 4, "flush_idle");
    do_fetch(32'h0, 1'b1, 5, 4, "flush_coincident");
    do_fetch(32'h0, 1'b0, 1, 0, "flush_refilled");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ce = 1'b1;
    addr = 32'h20;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #3;
    n_vec++;
    if (ready !== 1'b0 || data !== 32'h0 || mem_rd !== 1'b0 || mem_a !== '0) begin
      n_err++;
      $display("FAIL reset_mid: ready=%b data=%h rd=%b a=%h, required all zero", ready, data, mem_rd, mem_a);
    end
    rst = 1'b0;
    ce = 1'b0;
    repeat (8) @(negedge clk);
    do_fetch(32'h20, 1'b0, 5, 4, "after_reset");
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] ea [4];
    ea = '{17'h10, 17'h11, 17'h12, 17'h13};
    do_fetch(32'h0002_0010, 1'b0, 5, 4, "wrap");
    n_vec++;
    if (alog.size() != 4) begin
      n_err++;
      $display("FAIL wrap_addr_count: got %0d, required 4", alog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (alog[i] !== ea[i]) begin
          n_err++;
          $display("FAIL wrap_addr[%0d]: got %h, required %h", i, alog[i], ea[i]);
        end
      end
    end
    do_fetch(32'h13, 1'b0, 1, 0, "unaligned_hit");
  endtask

  task automatic test_abort_ce();
    @(negedge clk);
    ce = 1'b1;
    addr = 32'h40;
    repeat (2) @(negedge clk);
    ce = 1'b0;
    repeat (6) @(negedge clk);
    do_fetch(32'h10, 1'b0, 1, 0, "abort_keeps_buf");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ready_cyc.delete();
    rd_cnt = 0;
    repeat (3) exp_q.push_back(exp_word(32'h10));
    ce = 1'b1;
    addr = 32'h10;
    repeat (6) @(negedge clk);
    ce = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (ready_cyc.size() != 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d readies, required 3", ready_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_vec++;
        if (ready_cyc[i] - ready_cyc[i-1] != 2) begin
          n_err++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 2", i, ready_cyc[i] - ready_cyc[i-1]);
        end
      end
    end
    n_vec++;
    if (rd_cnt != 0) begin
      n_err++;
      $display("FAIL b2b_reads: got %0d strobes, required 0", rd_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37) + 11);
    mem[0] = 8'h13;
    mem[1] = 8'h05;
    mem[2] = 8'h10;
    mem[3] = 8'h00;
    rst = 1'b1;
    ce = 1'b0;
    flush = 1'b0;
    addr = 32'h0;

    test_reset();
    test_miss();
    test_hit();
    test_restart();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_abort_ce();
    test_back_to_back();

    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
